// File: rtl/key_unlock_pkg.sv
// Shared types and sizing helpers for the multi-word key unlock sequencer.
package key_unlock_pkg;

    // Controller states of the unlock sequencer.
    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        DRAIN   = 3'd1,
        EMIT    = 3'd2,
        FAILED  = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

    // Default configuration.
    localparam int DEF_KEY_W          = 32;
    localparam int DEF_KEY_WORDS      = 2;
    localparam int DEF_FLAG_WORDS     = 4;
    localparam int DEF_MAX_FAIL       = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1024;

    // Width of an index that walks 0..n-1. Never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that holds 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/key_unlock_seq_lockout_timer.sv
// Down-counter that runs for CYCLES clocks after start and flags the last one.
module lockout_timer
    import key_unlock_pkg::*;
#(
    parameter int CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int               CNT_W = cnt_width(CYCLES);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    // Load on start, then count down; busy drops after the cycle where the count is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            cnt_q  <= LOAD;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/key_unlock_seq.sv
// Multi-word key check: collects a key stream, compares it against a secret,
// streams out the de-obfuscated flag on success and enforces a lockout after
// too many consecutive failures.
module key_unlock_seq
    import key_unlock_pkg::*;
#(
    parameter int                          KEY_W          = DEF_KEY_W,
    parameter int                          KEY_WORDS      = DEF_KEY_WORDS,
    parameter int                          FLAG_WORDS     = DEF_FLAG_WORDS,
    parameter logic [KEY_WORDS*KEY_W-1:0]  KEY_SECRET     = {32'h0BADF00D, 32'h9DA79FF0},
    parameter logic [FLAG_WORDS*KEY_W-1:0] FLAG_ENC       = {32'h11111111, 32'h22222222,
                                                             32'h33333333, 32'h44444444},
    parameter int                          MAX_FAIL       = DEF_MAX_FAIL,
    parameter int                          LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic [KEY_W-1:0]              key_word,
    input  logic                          key_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [KEY_W-1:0]              data,
    output logic                          data_last,
    output logic                          pass,
    output logic                          fail,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int                FCNT_W    = cnt_width(MAX_FAIL);
    localparam int                KIDX_W    = idx_width(KEY_WORDS);
    localparam int                FIDX_W    = idx_width(FLAG_WORDS);
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_WORDS - 1);
    localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FLAG_WORDS - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(MAX_FAIL);

    function automatic logic [KEY_W-1:0] secret_word(input logic [KIDX_W-1:0] i);
        return KEY_SECRET[i*KEY_W +: KEY_W];
    endfunction

    function automatic logic [KEY_W-1:0] flag_word(input logic [FIDX_W-1:0] j);
        return FLAG_ENC[j*KEY_W +: KEY_W];
    endfunction

    state_e            state_q;
    logic              key_ready_q;
    logic              out_valid_q;
    logic              data_last_q;
    logic              pass_q;
    logic              fail_q;
    logic              locked_q;
    logic              mismatch_q;
    logic [KEY_W-1:0]  data_q;
    logic [FCNT_W-1:0] fail_cnt_q;
    logic [KIDX_W-1:0] idx_q;
    logic [KIDX_W-1:0] ptr_q;
    logic [FIDX_W-1:0] j_q;
    logic [KEY_W-1:0]  key_buf_q [KEY_WORDS];

    logic              key_hs;
    logic              out_hs;
    logic              last_word;
    logic              mismatch_d;
    logic [FCNT_W-1:0] fail_cnt_d;
    logic [FIDX_W-1:0] j_d;
    logic [KIDX_W-1:0] ptr_d;
    logic [KEY_W-1:0]  buf0_d;
    logic [KEY_W-1:0]  emit_data_d;

    logic              timer_start;
    logic              timer_busy;
    logic              timer_done;

    // Handshakes and next values shared by several FSM branches.
    always_comb begin
        key_hs      = key_valid && key_ready_q;
        out_hs      = out_valid_q && out_ready;
        last_word   = (idx_q == KIDX_LAST);
        mismatch_d  = mismatch_q || (key_word != secret_word(idx_q));
        fail_cnt_d  = (fail_cnt_q == FCNT_MAX) ? fail_cnt_q : fail_cnt_q + 1'b1;
        j_d         = j_q + 1'b1;
        ptr_d       = (ptr_q == KIDX_LAST) ? '0 : ptr_q + 1'b1;
        // Word 0 of the key may be the one arriving right now (single-word keys).
        buf0_d      = (idx_q == '0) ? key_word : key_buf_q[0];
        emit_data_d = flag_word(j_d) ^ key_buf_q[ptr_d];
    end

    // The lockout is armed from the one-cycle FAILED state once the limit is hit.
    assign timer_start = (state_q == FAILED) && (fail_cnt_q == FCNT_MAX) && !timer_busy;

    lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (timer_start),
        .busy  (timer_busy),
        .done  (timer_done)
    );

    // Sequencer FSM; every output is registered and set for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            key_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            data_last_q <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            data_q      <= '0;
            fail_cnt_q  <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            j_q         <= '0;
            for (int i = 0; i < KEY_WORDS; i++) begin
                key_buf_q[i] <= '0;
            end
        end else begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            unique case (state_q)
                COLLECT: begin
                    key_ready_q <= 1'b1;
                    if (key_hs) begin
                        key_buf_q[idx_q] <= key_word;
                        mismatch_q       <= mismatch_d;
                        idx_q            <= idx_q + 1'b1;
                        if (key_last && last_word && !mismatch_d) begin
                            state_q     <= EMIT;
                            key_ready_q <= 1'b0;
                            pass_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            j_q         <= '0;
                            ptr_q       <= '0;
                            data_q      <= flag_word('0) ^ buf0_d;
                            data_last_q <= (FIDX_LAST == '0);
                        end else if (key_last) begin
                            // Wrong content or a short key.
                            state_q     <= FAILED;
                            key_ready_q <= 1'b0;
                            fail_q      <= 1'b1;
                            fail_cnt_q  <= fail_cnt_d;
                            idx_q       <= '0;
                            mismatch_q  <= 1'b0;
                        end else if (last_word) begin
                            // Key is longer than expected: swallow the rest.
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    key_ready_q <= 1'b1;
                    if (key_hs && key_last) begin
                        state_q     <= FAILED;
                        key_ready_q <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_cnt_q  <= fail_cnt_d;
                        idx_q       <= '0;
                        mismatch_q  <= 1'b0;
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (data_last_q) begin
                            state_q     <= COLLECT;
                            key_ready_q <= 1'b1;
                            out_valid_q <= 1'b0;
                            data_q      <= '0;
                            data_last_q <= 1'b0;
                            j_q         <= '0;
                            ptr_q       <= '0;
                            idx_q       <= '0;
                            mismatch_q  <= 1'b0;
                            fail_cnt_q  <= '0;
                            for (int i = 0; i < KEY_WORDS; i++) begin
                                key_buf_q[i] <= '0;
                            end
                        end else begin
                            j_q         <= j_d;
                            ptr_q       <= ptr_d;
                            data_q      <= emit_data_d;
                            data_last_q <= (j_d == FIDX_LAST);
                        end
                    end
                end
                FAILED: begin
                    for (int i = 0; i < KEY_WORDS; i++) begin
                        key_buf_q[i] <= '0;
                    end
                    if (fail_cnt_q == FCNT_MAX) begin
                        state_q  <= LOCKOUT;
                        locked_q <= 1'b1;
                    end else begin
                        state_q     <= COLLECT;
                        key_ready_q <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer_done) begin
                        state_q     <= COLLECT;
                        locked_q    <= 1'b0;
                        fail_cnt_q  <= '0;
                        key_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    key_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign out_valid = out_valid_q;
    assign data      = data_q;
    assign data_last = data_last_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign locked    = locked_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_key_unlock_seq.sv
// Randomized bench for key_unlock_seq with a transaction-level reference model.
module tb_key_unlock_seq;

    localparam int KEY_W          = 32;
    localparam int KEY_WORDS      = 2;
    localparam int FLAG_WORDS     = 4;
    localparam int MAX_FAIL       = 3;
    localparam int LOCKOUT_CYCLES = 1024;
    localparam int FCW            = $clog2(MAX_FAIL + 1);

    localparam logic [KEY_W-1:0] SECRET   [KEY_WORDS]  = '{32'h9DA79FF0, 32'h0BADF00D};
    localparam logic [KEY_W-1:0] FLAG_ENC [FLAG_WORDS] = '{32'h44444444, 32'h33333333,
                                                           32'h22222222, 32'h11111111};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_valid = 1'b0;
    logic             key_last = 1'b0;
    logic             out_ready = 1'b1;
    logic [KEY_W-1:0] key_word = '0;
    logic             key_ready;
    logic             out_valid;
    logic             data_last;
    logic             pass;
    logic             fail;
    logic             locked;
    logic [KEY_W-1:0] data;
    logic [FCW-1:0]   fail_cnt;

    int               checks = 0;
    int               failures = 0;
    int               model_fails = 0;
    logic [KEY_W-1:0] attempt_q [$];

    always #5 clk = ~clk;

    key_unlock_seq #(
        .KEY_W          (KEY_W),
        .KEY_WORDS      (KEY_WORDS),
        .FLAG_WORDS     (FLAG_WORDS),
        .KEY_SECRET     ({32'h0BADF00D, 32'h9DA79FF0}),
        .FLAG_ENC       ({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}),
        .MAX_FAIL       (MAX_FAIL),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_word  (key_word),
        .key_last  (key_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data      (data),
        .data_last (data_last),
        .pass      (pass),
        .fail      (fail),
        .locked    (locked),
        .fail_cnt  (fail_cnt)
    );

    // kind: 0 correct, 1 wrong content, 2 short, 3 long with correct prefix
    task automatic make_attempt(input int kind);
        int w;
        attempt_q.delete();
        case (kind)
            0: for (int i = 0; i < KEY_WORDS; i++) attempt_q.push_back(SECRET[i]);
            1: begin
                for (int i = 0; i < KEY_WORDS; i++) attempt_q.push_back(SECRET[i]);
                w = $urandom_range(0, KEY_WORDS - 1);
                attempt_q[w] = attempt_q[w] ^ (32'h1 << $urandom_range(0, KEY_W - 1));
            end
            2: for (int i = 0; i < KEY_WORDS - 1; i++) attempt_q.push_back(SECRET[i]);
            default: begin
                for (int i = 0; i < KEY_WORDS; i++) attempt_q.push_back(SECRET[i]);
                w = $urandom_range(1, 2);
                for (int i = 0; i < w; i++) attempt_q.push_back(KEY_W'($urandom));
            end
        endcase
    endtask

    // Drives attempt_q and checks the outcome against the model.
    // bp_mode: 0 always ready, 1 toggle, 2 random. abort_after>=0 returns mid-EMIT.
    task automatic run_attempt(input int bp_mode, input int abort_after);
        int               n;
        int               idx;
        int               cyc;
        int               k;
        int               lock_len;
        int               bad_in_lock;
        bit               hs;
        bit               expect_pass;
        bit               tog;
        logic [KEY_W-1:0] exp_data [FLAG_WORDS];

        n = attempt_q.size();
        expect_pass = (n == KEY_WORDS);
        if (expect_pass)
            for (int i = 0; i < KEY_WORDS; i++)
                if (attempt_q[i] != SECRET[i]) expect_pass = 1'b0;
        for (int i = 0; i < FLAG_WORDS; i++)
            exp_data[i] = expect_pass ? (FLAG_ENC[i] ^ attempt_q[i % KEY_WORDS]) : '0;

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 100) begin
            @(negedge clk);
            key_valid = ($urandom_range(0, 3) != 0);
            key_word  = key_valid ? attempt_q[idx] : KEY_W'($urandom);
            key_last  = key_valid && (idx == n - 1);
            checks++;
            if (key_ready !== 1'b1) begin
                failures++;
                $display("FAIL key_ready_collect word=%0d got=%b want=1", idx, key_ready);
            end
            hs = key_valid && key_ready;
            @(posedge clk);
            if (hs) idx++;
            cyc++;
        end
        checks++;
        if (idx != n) begin
            failures++;
            $display("FAIL key_accept_timeout got=%0d want=%0d", idx, n);
        end
        @(negedge clk);
        key_valid = 1'b0;
        key_last  = 1'b0;

        if (expect_pass) begin
            checks++;
            if ({pass, fail, out_valid, key_ready} !== 4'b1010) begin
                failures++;
                $display("FAIL pass_pulse got pass=%b fail=%b ov=%b kr=%b want 1 0 1 0",
                         pass, fail, out_valid, key_ready);
            end
            k = 0;
            cyc = 0;
            tog = 1'b0;
            while (k < FLAG_WORDS && cyc < 200) begin
                if (abort_after >= 0 && k == abort_after) return;
                checks++;
                if ({out_valid, data, data_last, key_ready, fail_cnt} !==
                    {1'b1, exp_data[k], (k == FLAG_WORDS - 1), 1'b0, FCW'(model_fails)}) begin
                    failures++;
                    $display("FAIL flag_word%0d got ov=%b data=%h last=%b kr=%b cnt=%0d want 1 %h %b 0 %0d",
                             k, out_valid, data, data_last, key_ready, fail_cnt,
                             exp_data[k], (k == FLAG_WORDS - 1), model_fails);
                end
                if (cyc > 0) begin
                    checks++;
                    if (pass !== 1'b0) begin
                        failures++;
                        $display("FAIL pass_width cycle=%0d got=%b want=0", cyc, pass);
                    end
                end
                case (bp_mode)
                    0: out_ready = 1'b1;
                    1: begin
                        out_ready = tog;
                        tog = !tog;
                    end
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                hs = out_valid && out_ready;
                @(posedge clk);
                if (hs) k++;
                cyc++;
                @(negedge clk);
            end
            checks++;
            if (k != FLAG_WORDS) begin
                failures++;
                $display("FAIL emit_timeout got=%0d words want=%0d", k, FLAG_WORDS);
            end
            model_fails = 0;
            checks++;
            if ({out_valid, data, data_last, key_ready, fail_cnt} !==
                {1'b0, KEY_W'(0), 1'b0, 1'b1, FCW'(0)}) begin
                failures++;
                $display("FAIL emit_done got ov=%b data=%h last=%b kr=%b cnt=%0d want 0 0 0 1 0",
                         out_valid, data, data_last, key_ready, fail_cnt);
            end
            out_ready = 1'b1;
        end else begin
            if (model_fails < MAX_FAIL) model_fails++;
            checks++;
            if ({pass, fail, out_valid, key_ready, fail_cnt} !==
                {1'b0, 1'b1, 1'b0, 1'b0, FCW'(model_fails)}) begin
                failures++;
                $display("FAIL fail_pulse got pass=%b fail=%b ov=%b kr=%b cnt=%0d want 0 1 0 0 %0d",
                         pass, fail, out_valid, key_ready, fail_cnt, model_fails);
            end
            @(negedge clk);
            if (model_fails == MAX_FAIL) begin
                lock_len = 0;
                bad_in_lock = 0;
                while (locked === 1'b1 && lock_len < 4 * LOCKOUT_CYCLES) begin
                    if (key_ready !== 1'b0 || out_valid !== 1'b0) bad_in_lock++;
                    lock_len++;
                    @(negedge clk);
                end
                checks++;
                if (lock_len != LOCKOUT_CYCLES) begin
                    failures++;
                    $display("FAIL lockout_len got=%0d want=%0d", lock_len, LOCKOUT_CYCLES);
                end
                checks++;
                if (bad_in_lock != 0) begin
                    failures++;
                    $display("FAIL lockout_ready got=%0d busy cycles want=0", bad_in_lock);
                end
                model_fails = 0;
            end
            checks++;
            if ({fail, locked, out_valid, key_ready, fail_cnt} !==
                {1'b0, 1'b0, 1'b0, 1'b1, FCW'(model_fails)}) begin
                failures++;
                $display("FAIL after_fail got fail=%b lk=%b ov=%b kr=%b cnt=%0d want 0 0 0 1 %0d",
                         fail, locked, out_valid, key_ready, fail_cnt, model_fails);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({key_ready, out_valid, data, data_last, pass, fail, locked, fail_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_values got kr=%b ov=%b data=%h last=%b p=%b f=%b lk=%b cnt=%0d want all 0",
                     key_ready, out_valid, data, data_last, pass, fail, locked, fail_cnt);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (key_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got=%b want=0", key_ready);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got=%b want=1", key_ready);
        end
        model_fails = 0;
    endtask

    task automatic test_correct_key();
        make_attempt(0);
        run_attempt(0, -1);
    endtask

    task automatic test_wrong_key();
        make_attempt(1);
        run_attempt(0, -1);
    endtask

    task automatic test_lockout();
        make_attempt(0);
        run_attempt(0, -1);
        repeat (MAX_FAIL) begin
            make_attempt(1);
            run_attempt(2, -1);
        end
        make_attempt(0);
        run_attempt(0, -1);
    endtask

    task automatic test_short_long();
        make_attempt(2);
        run_attempt(0, -1);
        make_attempt(3);
        run_attempt(0, -1);
    endtask

    task automatic test_backpressure();
        make_attempt(0);
        run_attempt(1, -1);
    endtask

    task automatic test_random();
        repeat (12) begin
            make_attempt($urandom_range(0, 3));
            run_attempt($urandom_range(0, 2), -1);
        end
    endtask

    task automatic test_reset_mid_emit();
        make_attempt(0);
        run_attempt(0, -1);
        make_attempt(1);
        run_attempt(0, -1);
        make_attempt(0);
        run_attempt(0, 2);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL emit_before_reset got ov=%b want=1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, data, data_last, key_ready, fail_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset got ov=%b data=%h last=%b kr=%b cnt=%0d want all 0",
                     out_valid, data, data_last, key_ready, fail_cnt);
        end
        model_fails = 0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        make_attempt(1);
        run_attempt(0, -1);
    endtask

    initial begin
        test_reset();
        test_correct_key();
        test_wrong_key();
        test_lockout();
        test_short_long();
        test_backpressure();
        test_random();
        test_reset_mid_emit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
